tile_lane_scorer: RTL and testbench
===================================

Name: tile_lane_scorer

Overview:
- Downstream consumer of the song sequencer's per-lane note-spawn pulses (block1..4) and key-press levels (kill1..4).
- Holds up to DEPTH falling tiles per lane and advances them once per frame_tick by speed.
- Judges key presses against a hit window and counts score and misses; ends the game at MAX_MISS.
- Exposes a read port so the renderer can fetch tile positions.

Parameters:
- DEPTH, 4: tile slots per lane (power of 2).
- Y_W, 10: tile y-position width.
- SCREEN_H, 480: y at or above which a tile has expired.
- HIT_LO, 400: lowest y, inclusive, of the hit window.
- HIT_HI, 460: highest y, inclusive, of the hit window.
- MAX_MISS, 3: miss count that forces game over.

Ports:
- Clk  in  1  system clock.
- Reset  in  1  asynchronous, active-high reset.
- start  in  1  1-cycle pulse; begins or restarts a game.
- frame_tick  in  1  1-cycle pulse per video frame.
- speed  in  4  lines per frame_tick.
- block  in  4  spawn pulses; bit i = lane i+1.
- kill  in  4  key-held levels from a different clock domain.
- rd_lane  in  2  renderer lane select.
- rd_idx  in  log2(DEPTH)  slot offset from the oldest tile.
- rd_y  out  Y_W  y of the selected tile; combinational.
- rd_valid  out  1  selected slot is occupied; combinational.
- score  out  16  hit count, saturating.
- misses  out  4  miss count.
- game_over  out  1  high in the OVER state.
- playing  out  1  high in the PLAY state.
- overflow  out  1  sticky; a spawn was dropped because its lane was full.

Behaviour:
- Reset (async): state=IDLE, all lanes empty, score=0, misses=0, overflow=0, synchronizer flops=0. All outputs read 0.
- FSM:
  - IDLE -> PLAY on start.
  - PLAY -> OVER in the cycle after misses reaches MAX_MISS.
  - OVER -> PLAY on start.
  - A start pulse in any state clears lanes, score, misses and overflow, then enters PLAY.
- kill handling: each bit passes through a 2-flop synchronizer, then a rising-edge detector. A press event is therefore a 1-cycle pulse 3 Clk cycles after kill rises. A held key produces exactly one event.
- Lane storage: per lane, a ring buffer with head/tail pointers and an occupancy count of 0..DEPTH. The head is the oldest tile, which also has the largest y.
- Spawn (PLAY only): block[i] writes y=0 at the tail.
  - If the lane is full, the spawn is dropped and overflow is set.
  - A spawn arriving in the same cycle as frame_tick is not advanced on that tick.
- Advance: on frame_tick in PLAY, every occupied entry gets y <= y + speed, saturating at 2^Y_W-1. The sum is computed at Y_W+1 bits.
- Expiry: in the cycle after a frame_tick, if the head's y >= SCREEN_H, the head is popped and misses increments. At most one expiry per lane per cycle; additional expired entries are popped in subsequent cycles.
- Press event in lane i (PLAY only):
  - Lane non-empty and head y in [HIT_LO, HIT_HI]: pop head, score += 1 (saturating at 16'hFFFF).
  - Otherwise (empty lane or head outside the window): misses += 1, no pop.
- Same lane and cycle, press and expiry both pending: the press is judged first. If it hits, the expiry check is skipped that cycle. If it misses, the expiry is processed as well and misses += 2.
- Same cycle, spawn plus pop in one lane: both occur and the count is unchanged.
- Miss arithmetic:
  - Per-cycle increments from all lanes are summed, at most 8.
  - misses saturates at MAX_MISS.
  - Once misses == MAX_MISS, further spawns, presses and ticks are ignored.
- IDLE and OVER: tiles frozen, spawns and presses ignored, rd_* still readable.
- Read port: rd_valid = (rd_idx < count[rd_lane]); rd_y = entry at head+rd_idx. When rd_valid=0, rd_y=0.

Test Plan:
1. Reset mid-game with score=5 and 3 tiles held -> all outputs 0 immediately, before the next Clk edge, and stay 0 until start.
2. start, block=4'b0001, speed=8, then 50 frame_ticks -> lane0 head y=400. Raise kill[0] -> 3 cycles later score=1, rd_valid(lane0, idx0)=0.
3. Spawn in lane2, speed=15, 32 ticks -> y=480, expires; misses=1 the cycle after the tick, score=0.
4. Press kill[1] with lane1 empty, then hold it high for 100 cycles -> misses=1 exactly, not 100.
5. Five spawns into lane3 with no ticks -> count=4, overflow=1, rd_y=0 for idx 0..3.
6. Three misses -> game_over=1 and playing=0 on the next cycle. A further kill -> no change. Then start -> score=0, misses=0, playing=1.

Source files
------------

// File: rtl/tile_lane_scorer.sv
// Four-lane falling-tile store: spawns tiles at y=0, advances them per frame_tick,
// judges synchronized key presses against a hit window, and keeps score/miss counts.
module tile_lane_scorer #(
  parameter int DEPTH    = 4,
  parameter int Y_W      = 10,
  parameter int SCREEN_H = 480,
  parameter int HIT_LO   = 400,
  parameter int HIT_HI   = 460,
  parameter int MAX_MISS = 3
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     start,
  input  logic                     frame_tick,
  input  logic [3:0]               speed,
  input  logic [3:0]               block,
  input  logic [3:0]               kill,
  input  logic [1:0]               rd_lane,
  input  logic [$clog2(DEPTH)-1:0] rd_idx,
  output logic [Y_W-1:0]           rd_y,
  output logic                     rd_valid,
  output logic [15:0]              score,
  output logic [3:0]               misses,
  output logic                     game_over,
  output logic                     playing,
  output logic                     overflow
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PLAY = 2'd1;
  localparam logic [1:0] S_OVER = 2'd2;
  localparam logic [Y_W-1:0] SCR_Y = Y_W'(SCREEN_H);
  localparam logic [Y_W-1:0] LO_Y  = Y_W'(HIT_LO);
  localparam logic [Y_W-1:0] HI_Y  = Y_W'(HIT_HI);
  localparam logic [3:0]     MAX_M = 4'(MAX_MISS);

  function automatic logic [Y_W-1:0] sat_add_y(input logic [Y_W-1:0] y, input logic [3:0] s);
    logic [Y_W:0] sum;
    sum = {1'b0, y} + {{(Y_W-3){1'b0}}, s};
    return sum[Y_W] ? {Y_W{1'b1}} : sum[Y_W-1:0];
  endfunction

  function automatic logic [15:0] sat_add_score(input logic [15:0] sc, input logic [2:0] n);
    logic [16:0] sum;
    sum = {1'b0, sc} + {14'd0, n};
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

  function automatic logic [3:0] sat_add_miss(input logic [3:0] m, input logic [3:0] n);
    logic [4:0] sum;
    sum = {1'b0, m} + {1'b0, n};
    return (sum >= {1'b0, MAX_M}) ? MAX_M : sum[3:0];
  endfunction

  logic [1:0]     state;
  logic [3:0]     ks1, ks2, ks3;
  logic [PW-1:0]  head [4];
  logic [PW-1:0]  tail [4];
  logic [CW-1:0]  cnt  [4];
  logic [Y_W-1:0] ty   [4][DEPTH];

  logic           active;
  logic [3:0]     press, hit, expire, pop, push, drop;
  logic [Y_W-1:0] head_y [4];
  logic [3:0]     miss_inc;
  logic [2:0]     hit_cnt;

  // Once the miss limit is reached the field freezes until the FSM leaves PLAY.
  assign active = (state == S_PLAY) && (misses != MAX_M);
  assign press  = ks2 & ~ks3;

  always_comb begin
    hit      = '0;
    expire   = '0;
    pop      = '0;
    push     = '0;
    drop     = '0;
    miss_inc = '0;
    hit_cnt  = '0;
    for (int l = 0; l < 4; l++) begin
      head_y[l] = ty[l][head[l]];
      if (active) begin
        if (press[l] && cnt[l] != '0 && head_y[l] >= LO_Y && head_y[l] <= HI_Y)
          hit[l] = 1'b1;
        else if (press[l])
          miss_inc = miss_inc + 4'd1;
        // A missed press does not shield an expired head; both count.
        if (!hit[l] && cnt[l] != '0 && head_y[l] >= SCR_Y) begin
          expire[l] = 1'b1;
          miss_inc  = miss_inc + 4'd1;
        end
        pop[l] = hit[l] | expire[l];
        if (block[l]) begin
          if (cnt[l] == CW'(DEPTH)) drop[l] = 1'b1;
          else                      push[l] = 1'b1;
        end
        hit_cnt = hit_cnt + {2'b0, hit[l]};
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state    <= S_IDLE;
      score    <= '0;
      misses   <= '0;
      overflow <= 1'b0;
      ks1      <= '0;
      ks2      <= '0;
      ks3      <= '0;
      for (int l = 0; l < 4; l++) begin
        head[l] <= '0;
        tail[l] <= '0;
        cnt[l]  <= '0;
      end
    end else begin
      ks1 <= kill;
      ks2 <= ks1;
      ks3 <= ks2;
      if (start) begin
        state    <= S_PLAY;
        score    <= '0;
        misses   <= '0;
        overflow <= 1'b0;
        for (int l = 0; l < 4; l++) begin
          head[l] <= '0;
          tail[l] <= '0;
          cnt[l]  <= '0;
        end
      end else begin
        if (state == S_PLAY && misses == MAX_M) state <= S_OVER;
        score  <= sat_add_score(score, hit_cnt);
        misses <= sat_add_miss(misses, miss_inc);
        if (|drop) overflow <= 1'b1;
        for (int l = 0; l < 4; l++) begin
          if (pop[l])  head[l] <= head[l] + PW'(1);
          if (push[l]) tail[l] <= tail[l] + PW'(1);
          cnt[l] <= cnt[l] + CW'(push[l]) - CW'(pop[l]);
        end
      end
    end
  end

  // Tile positions carry no reset; occupancy alone decides which slots are live.
  always_ff @(posedge Clk) begin
    for (int l = 0; l < 4; l++) begin
      for (int s = 0; s < DEPTH; s++) begin
        if (active && push[l] && PW'(s) == tail[l])
          ty[l][s] <= '0;
        else if (active && frame_tick && ({1'b0, PW'(s) - head[l]} < cnt[l]))
          ty[l][s] <= sat_add_y(ty[l][s], speed);
      end
    end
  end

  logic [PW-1:0] rd_slot;
  assign rd_slot   = head[rd_lane] + rd_idx;
  assign rd_valid  = {1'b0, rd_idx} < cnt[rd_lane];
  assign rd_y      = rd_valid ? ty[rd_lane][rd_slot] : '0;
  assign game_over = (state == S_OVER);
  assign playing   = (state == S_PLAY);
endmodule

// File: tb/tb_tile_lane_scorer.sv
// Bench for tile_lane_scorer: per-lane tile lists model checked every cycle,
// plus directed scenarios with hand-computed expectations.
`timescale 1ns/100ps
module tb_tile_lane_scorer;
  localparam int DEPTH = 4, Y_W = 10, SCREEN_H = 480, HIT_LO = 400, HIT_HI = 460, MAX_MISS = 3;

  logic        Clk = 1'b0, Reset = 1'b1, start = 1'b0, frame_tick = 1'b0;
  logic [3:0]  speed = '0, block = '0, kill = '0;
  logic [1:0]  rd_lane = '0;
  logic [1:0]  rd_idx = '0;
  logic [9:0]  rd_y;
  logic        rd_valid;
  logic [15:0] score;
  logic [3:0]  misses;
  logic        game_over, playing, overflow;

  int checks = 0, errors = 0;

  tile_lane_scorer #(.DEPTH(DEPTH), .Y_W(Y_W), .SCREEN_H(SCREEN_H), .HIT_LO(HIT_LO),
                     .HIT_HI(HIT_HI), .MAX_MISS(MAX_MISS)) dut (
    .Clk(Clk), .Reset(Reset), .start(start), .frame_tick(frame_tick), .speed(speed),
    .block(block), .kill(kill), .rd_lane(rd_lane), .rd_idx(rd_idx), .rd_y(rd_y),
    .rd_valid(rd_valid), .score(score), .misses(misses), .game_over(game_over),
    .playing(playing), .overflow(overflow));

  always #5 Clk = ~Clk;

  function automatic void chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Model: each lane is a list ordered oldest first; mode 0 idle, 1 play, 2 over.
  int   my [4][DEPTH];
  int   mn [4];
  int   m_score, m_misses, m_mode;
  bit   m_ovf;
  logic [3:0] h1, h2, h3;

  task automatic model_clear_lanes();
    for (int l = 0; l < 4; l++) mn[l] = 0;
    m_score = 0; m_misses = 0; m_ovf = 0;
  endtask

  task automatic model_pop(int l);
    for (int k = 0; k < DEPTH - 1; k++) my[l][k] = my[l][k+1];
    mn[l]--;
  endtask

  task automatic model_step();
    logic [3:0] pr;
    int inc, hits;
    bit full, popped;
    pr = h2 & ~h3;
    h3 = h2; h2 = h1; h1 = kill;
    if (start) begin
      model_clear_lanes();
      m_mode = 1;
    end else if (m_mode == 1) begin
      if (m_misses == MAX_MISS) m_mode = 2;
      else begin
        inc = 0; hits = 0;
        for (int l = 0; l < 4; l++) begin
          full = (mn[l] == DEPTH);
          popped = 0;
          if (pr[l]) begin
            if (mn[l] > 0 && my[l][0] >= HIT_LO && my[l][0] <= HIT_HI) begin
              model_pop(l); hits++; popped = 1;
            end else inc++;
          end
          if (!popped && mn[l] > 0 && my[l][0] >= SCREEN_H) begin
            model_pop(l); inc++;
          end
          if (frame_tick)
            for (int k = 0; k < mn[l]; k++)
              my[l][k] = (my[l][k] + int'(speed) > 1023) ? 1023 : my[l][k] + int'(speed);
          if (block[l]) begin
            if (full) m_ovf = 1;
            else begin my[l][mn[l]] = 0; mn[l]++; end
          end
        end
        m_misses = (m_misses + inc > MAX_MISS) ? MAX_MISS : m_misses + inc;
        m_score  = (m_score + hits > 65535) ? 65535 : m_score + hits;
      end
    end
  endtask

  always @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      model_clear_lanes();
      m_mode = 0; h1 = '0; h2 = '0; h3 = '0;
    end else model_step();
  end

  // Every cycle: registered outputs and the full read port against the model.
  int snap_v [4][DEPTH];
  int snap_y [4][DEPTH];
  always @(negedge Clk) begin
    chk("score", score, m_score);
    chk("misses", misses, m_misses);
    chk("game_over", game_over, m_mode == 2);
    chk("playing", playing, m_mode == 1);
    chk("overflow", overflow, m_ovf);
    for (int l = 0; l < 4; l++) begin
      for (int k = 0; k < DEPTH; k++) begin
        rd_lane = 2'(l); rd_idx = 2'(k);
        #0.2;
        chk("rd_valid", rd_valid, k < mn[l]);
        chk("rd_y", rd_y, (k < mn[l]) ? my[l][k] : 0);
        snap_v[l][k] = rd_valid;
        snap_y[l][k] = rd_y;
      end
    end
  end

  task automatic settle(); @(negedge Clk); #4; endtask
  task automatic pulse_start(); @(negedge Clk); start = 1; @(negedge Clk); start = 0; endtask
  task automatic spawn(logic [3:0] m); @(negedge Clk); block = m; @(negedge Clk); block = 0; endtask
  task automatic ticks(int n);
    repeat (n) begin @(negedge Clk); frame_tick = 1; @(negedge Clk); frame_tick = 0; end
  endtask
  task automatic press(logic [3:0] m, int hold);
    @(negedge Clk); kill = kill | m;
    repeat (hold) @(negedge Clk);
    kill = kill & ~m;
    repeat (4) @(negedge Clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    repeat (2) @(negedge Clk);
    Reset = 0;
    settle();
    chk("lit_reset_score", score, 0);
    chk("lit_reset_playing", playing, 0);

    // Hit at y=400 with speed 8 after 50 ticks; press lands 3 cycles after kill rises.
    pulse_start();
    speed = 8;
    spawn(4'b0001);
    ticks(50);
    settle();
    chk("lit_model_y400", my[0][0], 400);
    chk("lit_rd_y400", snap_y[0][0], 400);
    @(negedge Clk); kill = 4'b0001;
    repeat (2) @(negedge Clk); #4;
    chk("lit_score_before_latency", score, 0);
    @(negedge Clk); #4;
    chk("lit_score_hit", score, 1);
    chk("lit_lane0_empty", snap_v[0][0], 0);
    kill = 0;
    repeat (4) @(negedge Clk);

    // Expiry at y=480, counted the cycle after the tick.
    pulse_start();
    speed = 15;
    spawn(4'b0100);
    ticks(31);
    settle();
    chk("lit_y465", snap_y[2][0], 465);
    @(negedge Clk); frame_tick = 1; @(negedge Clk); frame_tick = 0; #4;
    chk("lit_y480", snap_y[2][0], 480);
    chk("lit_misses_tick_cycle", misses, 0);
    @(negedge Clk); #4;
    chk("lit_misses_expired", misses, 1);
    chk("lit_lane2_popped", snap_v[2][0], 0);
    chk("lit_score_zero", score, 0);

    // Held key on an empty lane yields a single miss.
    pulse_start();
    press(4'b0010, 100);
    settle();
    chk("lit_held_once", misses, 1);

    // Overflow on the fifth spawn into a lane.
    pulse_start();
    @(negedge Clk); block = 4'b1000;
    repeat (5) @(negedge Clk);
    block = 0;
    settle();
    chk("lit_overflow", overflow, 1);
    for (int k = 0; k < DEPTH; k++) begin
      chk("lit_full_valid", snap_v[3][k], 1);
      chk("lit_full_y0", snap_y[3][k], 0);
    end

    // Miss saturation and game over, then restart.
    press(4'b0001, 3);
    settle();
    chk("lit_miss1", misses, 1);
    @(negedge Clk); kill = 4'b0111;
    repeat (3) @(negedge Clk); #4;
    chk("lit_miss_sat", misses, 3);
    chk("lit_still_playing", playing, 1);
    @(negedge Clk); #4;
    chk("lit_game_over", game_over, 1);
    chk("lit_not_playing", playing, 0);
    kill = 0;
    repeat (3) @(negedge Clk);
    press(4'b1000, 3);
    spawn(4'b0001);
    ticks(2);
    settle();
    chk("lit_over_frozen_misses", misses, 3);
    chk("lit_over_frozen_lane0", snap_v[0][0], 0);
    chk("lit_over_frozen_lane3", snap_v[3][3], 1);
    pulse_start();
    settle();
    chk("lit_restart_score", score, 0);
    chk("lit_restart_misses", misses, 0);
    chk("lit_restart_playing", playing, 1);
    chk("lit_restart_overflow", overflow, 0);
    chk("lit_restart_lane3", snap_v[3][0], 0);

    // Build score 5 with 3 tiles held, then reset asynchronously.
    speed = 15;
    spawn(4'b1111);
    ticks(27);
    press(4'b1111, 6);
    spawn(4'b0001);
    ticks(27);
    press(4'b0001, 6);
    spawn(4'b0111);
    settle();
    chk("lit_score5", score, 5);
    chk("lit_three_tiles", snap_v[0][0] + snap_v[1][0] + snap_v[2][0], 3);
    @(posedge Clk); #2; Reset = 1; #1;
    chk("lit_async_score", score, 0);
    chk("lit_async_playing", playing, 0);
    chk("lit_async_rd_valid", rd_valid, 0);
    chk("lit_async_rd_y", rd_y, 0);
    @(negedge Clk); #1; Reset = 0;
    spawn(4'b0001);
    press(4'b0001, 3);
    settle();
    chk("lit_idle_ignored_lane", snap_v[0][0], 0);
    chk("lit_idle_misses", misses, 0);
    chk("lit_idle_playing", playing, 0);
    pulse_start();
    settle();
    chk("lit_final_playing", playing, 1);

    repeat (2) @(negedge Clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
